// File: rtl/gpio_serial_loader.sv
// ---------------------------------------------------------------------------
// gpio_serial_loader
//
// Sequencer for the serial configuration chain that threads through every
// GPIO control block around the padframe. On a start request it fetches one
// PAD_CTRL_BITS word per I/O from the management register file, shifts all
// of them out on a generated serial_clock, then pulses serial_load so every
// block latches its word at the same time.
//
// Words go out from I/O NUM_IO-1 down to I/O 0, MSB first, because each block
// shifts into its LSB and forwards its MSB down the chain: the first bit sent
// ends up in the block farthest from the loader.
//
// Ports
//   core_clk         in   block clock
//   resetn           in   synchronous, active-low reset
//   start            in   transfer request, honoured only while idle
//   cfg_idx          out  index of the I/O whose word is being requested
//   cfg_data         in   word for cfg_idx (combinational read)
//   serial_clock     out  chain shift clock (registered)
//   serial_data_out  out  chain data into block 0 (registered)
//   serial_load      out  chain latch strobe (registered)
//   busy             out  transfer in progress
//   done             out  one-cycle completion pulse (first idle cycle)
// ---------------------------------------------------------------------------
module gpio_serial_loader #(
    parameter int NUM_IO        = 38,
    parameter int PAD_CTRL_BITS = 10,
    parameter int CLK_DIV       = 4
) (
    input  logic                      core_clk,
    input  logic                      resetn,
    input  logic                      start,
    output logic [$clog2(NUM_IO)-1:0] cfg_idx,
    input  logic [PAD_CTRL_BITS-1:0]  cfg_data,
    output logic                      serial_clock,
    output logic                      serial_data_out,
    output logic                      serial_load,
    output logic                      busy,
    output logic                      done
);

    localparam int N       = NUM_IO * PAD_CTRL_BITS;
    localparam int IDX_W   = $clog2(NUM_IO);
    localparam int BIT_W   = $clog2(N + 1);
    localparam int PHASE_W = $clog2(CLK_DIV + 1);
    localparam int WBIT_W  = (PAD_CTRL_BITS > 1) ? $clog2(PAD_CTRL_BITS) : 1;

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_IO - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(N - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_DIV - 1);
    localparam logic [WBIT_W-1:0]  WBIT_LAST  = WBIT_W'(PAD_CTRL_BITS - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SHIFT_LO = 3'd1;
    localparam logic [2:0] SHIFT_HI = 3'd2;
    localparam logic [2:0] LOAD_LO  = 3'd3;
    localparam logic [2:0] LOAD_HI  = 3'd4;

    logic [2:0]               state;
    logic [2:0]               next_state;
    logic [PHASE_W-1:0]       phase;     // cycles spent in the current state
    logic [BIT_W-1:0]         bit_cnt;   // bits already sent in this transfer
    logic [WBIT_W-1:0]        word_bit;  // position of the current bit in its word
    logic [PAD_CTRL_BITS-1:0] word_reg;  // remaining bits of the current word, MSB next

    logic phase_last;
    logic last_bit;
    logic word_last;
    logic load_first;   // entering SHIFT_LO with the first bit of a new word
    logic shift_next;   // entering SHIFT_LO with the next bit of the same word

    assign phase_last = (phase == PHASE_LAST);
    assign last_bit   = (bit_cnt == BIT_LAST);
    assign word_last  = (word_bit == WBIT_LAST);

    assign load_first = ((state == IDLE) && start) ||
                        ((state == SHIFT_HI) && phase_last && !last_bit && word_last);
    assign shift_next = (state == SHIFT_HI) && phase_last && !last_bit && !word_last;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start)      next_state = SHIFT_LO;
            SHIFT_LO: if (phase_last) next_state = SHIFT_HI;
            SHIFT_HI: if (phase_last) next_state = last_bit ? LOAD_LO : SHIFT_LO;
            LOAD_LO:  if (phase_last) next_state = LOAD_HI;
            LOAD_HI:  if (phase_last) next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they change on the same
    // edge as the state register without any combinational decode glitches.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of order.
    always_ff @(posedge core_clk) begin
        if (!resetn) begin
            state           <= IDLE;
            phase           <= '0;
            bit_cnt         <= '0;
            word_bit        <= '0;
            cfg_idx         <= IDX_LAST;
            serial_clock    <= 1'b0;
            serial_data_out <= 1'b0;
            serial_load     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state        <= next_state;
            serial_clock <= (next_state == SHIFT_HI);
            serial_load  <= (next_state == LOAD_HI);
            busy         <= (next_state != IDLE);
            done         <= (state == LOAD_HI) && phase_last;

            if (next_state != state) begin
                phase <= '0;
            end else if (state != IDLE) begin
                phase <= phase + 1'b1;
            end

            if ((state == IDLE) && start) begin
                bit_cnt  <= '0;
                word_bit <= '0;
            end else if (load_first || shift_next) begin
                bit_cnt  <= bit_cnt + 1'b1;
                word_bit <= word_last ? '0 : word_bit + 1'b1;
            end

            if (load_first) begin
                serial_data_out <= cfg_data[PAD_CTRL_BITS-1];
            end else if (shift_next) begin
                serial_data_out <= word_reg[PAD_CTRL_BITS-1];
            end

            // Step to the next word as the last bit of this one is clocked,
            // leaving cfg_data a full half-period to settle before capture.
            if ((state == SHIFT_LO) && phase_last && word_last && (cfg_idx != '0)) begin
                cfg_idx <= cfg_idx - 1'b1;
            end else if ((state == LOAD_HI) && phase_last) begin
                cfg_idx <= IDX_LAST;
            end
        end
    end

    // NOTE: word_reg carries no reset; it is always loaded from cfg_data
    // before any of its bits are sent, so its power-up value is never seen.
    always_ff @(posedge core_clk) begin
        if (load_first) begin
            word_reg <= cfg_data << 1;
        end else if (shift_next) begin
            word_reg <= word_reg << 1;
        end
    end

endmodule
